ts_packet_buffer: RTL and testbench

Per-source TS packet FIFO that sits directly upstream of the four-input source switch, one instance per tuner input. It accepts a byte-parallel transport stream, aligns on sync bytes, and stores only complete 188-byte packets. It raises GOT_FULL_PACKET while at least one complete packet is stored. On a one-cycle GIVE_ME_ONE_PACKET request it streams exactly one packet, one byte per clock, with the fixed latency the switch expects.

---
 rtl/ts_packet_buffer.sv | 181 ++++++++++++++++++
 tb/tb_ts_packet_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_packet_buffer.sv
// Per-source TS packet FIFO: aligns on sync bytes, stores only complete
// 188-byte packets and replays one packet per request with fixed latency.
module ts_packet_buffer #(
  parameter int         SLOTS     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic                     SYS_CLK,
  input  logic                     RST,
  input  logic [7:0]               DATA_IN,
  input  logic                     D_VALID_IN,
  input  logic                     P_SYNC_IN,
  input  logic                     GIVE_ME_ONE_PACKET,
  output logic                     GOT_FULL_PACKET,
  output logic [7:0]               DATA_OUT,
  output logic                     READING,
  output logic [$clog2(SLOTS):0]   PKT_COUNT,
  output logic [7:0]               DROP_CNT,
  output logic [7:0]               SYNC_ERR_CNT
);

  localparam int SW       = $clog2(SLOTS);
  localparam int CW       = SW + 1;
  localparam int AW       = SW + 8;
  localparam int LAST_IDX = 187;
  localparam int RD_DONE  = 189;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wr_state_e;

  wr_state_e       wr_state, wr_state_next;
  logic [SW-1:0]   wr_slot, rd_slot;
  logic [7:0]      wr_idx, wr_idx_next;
  logic            mem_we;
  logic [7:0]      mem_wr_idx;
  logic            commit, drop_inc, err_inc;
  logic [CW:0]     occupancy;
  logic            slot_free, pkt_start, start_ok, start_drop, accept;
  logic [7:0]      rd_cnt;
  logic            rd_addr_valid;
  logic [AW-1:0]   rd_addr;
  logic [CW-1:0]   pkt_count_next;
  logic [7:0]      mem [SLOTS*256];

  // The slot being read out stays occupied until its last byte has left.
  always_comb begin
    occupancy  = {1'b0, PKT_COUNT} + {{CW{1'b0}}, READING};
    slot_free  = occupancy < (CW+1)'(SLOTS);
    pkt_start  = D_VALID_IN && P_SYNC_IN && (DATA_IN == SYNC_BYTE);
    start_ok   = pkt_start && slot_free;
    start_drop = pkt_start && !slot_free;
    accept     = GIVE_ME_ONE_PACKET && (PKT_COUNT != '0) && !READING;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    wr_state_next = wr_state;
    wr_idx_next   = wr_idx;
    mem_we        = 1'b0;
    mem_wr_idx    = wr_idx;
    commit        = 1'b0;
    drop_inc      = 1'b0;
    err_inc       = 1'b0;
    case (wr_state)
      W_IDLE, W_DROP: begin
        if (start_ok) begin
          mem_we        = 1'b1;
          mem_wr_idx    = 8'd0;
          wr_idx_next   = 8'd1;
          wr_state_next = W_FILL;
        end else if (start_drop) begin
          drop_inc      = 1'b1;
          wr_state_next = W_DROP;
        end
      end
      W_FILL: begin
        if (D_VALID_IN) begin
          if (P_SYNC_IN) begin
            // Early sync aborts the partial packet; the byte itself may
            // open the next packet in the same cycle.
            err_inc = 1'b1;
            if (start_ok) begin
              mem_we        = 1'b1;
              mem_wr_idx    = 8'd0;
              wr_idx_next   = 8'd1;
              wr_state_next = W_FILL;
            end else if (start_drop) begin
              drop_inc      = 1'b1;
              wr_state_next = W_DROP;
            end else begin
              wr_state_next = W_IDLE;
            end
          end else begin
            mem_we = 1'b1;
            if (wr_idx == 8'(LAST_IDX)) begin
              commit        = 1'b1;
              wr_state_next = W_IDLE;
            end else begin
              wr_idx_next = wr_idx + 8'd1;
            end
          end
        end
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      wr_state <= W_IDLE;
      wr_idx   <= 8'd0;
      wr_slot  <= '0;
    end else begin
      wr_state <= wr_state_next;
      wr_idx   <= wr_idx_next;
      if (commit) wr_slot <= wr_slot + SW'(1);
    end
  end

  // NOTE: packet storage has no reset; a slot is only ever read after a full
  // commit has overwritten all 188 bytes, so stale contents are never seen.
  always_ff @(posedge SYS_CLK) begin
    if (mem_we) mem[{wr_slot, mem_wr_idx}] <= DATA_IN;
  end

  // Address goes out one edge after accept, data lands in DATA_OUT one later.
  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      READING       <= 1'b0;
      rd_cnt        <= 8'd0;
      rd_slot       <= '0;
      rd_addr_valid <= 1'b0;
      rd_addr       <= '0;
      DATA_OUT      <= 8'h00;
    end else begin
      rd_addr_valid <= 1'b0;
      if (accept) begin
        READING <= 1'b1;
        rd_cnt  <= 8'd0;
      end else if (READING) begin
        if (rd_cnt == 8'(RD_DONE)) begin
          READING <= 1'b0;
          rd_slot <= rd_slot + SW'(1);
        end else begin
          rd_cnt <= rd_cnt + 8'd1;
        end
        if (rd_cnt <= 8'(LAST_IDX)) begin
          rd_addr_valid <= 1'b1;
          rd_addr       <= {rd_slot, rd_cnt};
        end
      end
      DATA_OUT <= rd_addr_valid ? mem[rd_addr] : 8'h00;
    end
  end

  always_comb begin
    pkt_count_next = PKT_COUNT;
    if (commit && !accept)      pkt_count_next = PKT_COUNT + CW'(1);
    else if (accept && !commit) pkt_count_next = PKT_COUNT - CW'(1);
  end

  always_ff @(posedge SYS_CLK) begin
    if (RST) begin
      PKT_COUNT       <= '0;
      GOT_FULL_PACKET <= 1'b0;
      DROP_CNT        <= 8'd0;
      SYNC_ERR_CNT    <= 8'd0;
    end else begin
      PKT_COUNT       <= pkt_count_next;
      GOT_FULL_PACKET <= (pkt_count_next != '0);
      if (drop_inc && (DROP_CNT != 8'hFF))    DROP_CNT     <= DROP_CNT + 8'd1;
      if (err_inc && (SYNC_ERR_CNT != 8'hFF)) SYNC_ERR_CNT <= SYNC_ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_ts_packet_buffer.sv
// Bench for ts_packet_buffer: a step table of packet writes/reads with a byte
// scoreboard, plus hand-written same-edge, ignored-request and reset sequences.
module tb_ts_packet_buffer;

  localparam int SLOTS = 4;
  localparam int LEN   = 188;

  logic                   SYS_CLK = 1'b0;
  logic                   RST;
  logic [7:0]             DATA_IN;
  logic                   D_VALID_IN;
  logic                   P_SYNC_IN;
  logic                   GIVE_ME_ONE_PACKET;
  logic                   GOT_FULL_PACKET;
  logic [7:0]             DATA_OUT;
  logic                   READING;
  logic [$clog2(SLOTS):0] PKT_COUNT;
  logic [7:0]             DROP_CNT;
  logic [7:0]             SYNC_ERR_CNT;

  ts_packet_buffer #(.SLOTS(SLOTS), .SYNC_BYTE(8'h47)) dut (
    .SYS_CLK            (SYS_CLK),
    .RST                (RST),
    .DATA_IN            (DATA_IN),
    .D_VALID_IN         (D_VALID_IN),
    .P_SYNC_IN          (P_SYNC_IN),
    .GIVE_ME_ONE_PACKET (GIVE_ME_ONE_PACKET),
    .GOT_FULL_PACKET    (GOT_FULL_PACKET),
    .DATA_OUT           (DATA_OUT),
    .READING            (READING),
    .PKT_COUNT          (PKT_COUNT),
    .DROP_CNT           (DROP_CNT),
    .SYNC_ERR_CNT       (SYNC_ERR_CNT)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         model_cnt = 0;

  typedef enum {OP_WRITE, OP_READ} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] seed;
    bit         gappy;
    int         len;
    int         exp_cnt;
    int         exp_drop;
    int         exp_err;
  } step_t;

  step_t steps[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  function automatic logic [7:0] pkt_byte(input logic [7:0] seed, input int i);
    logic [7:0] v;
    v = seed + 8'(i);
    return (i == 0) ? 8'h47 : v;
  endfunction

  task automatic push_packet(input logic [7:0] seed);
    for (int i = 0; i < LEN; i++) exp_q.push_back(pkt_byte(seed, i));
  endtask

  // Drives len bytes of a packet; with gappy set, an invalid cycle follows each byte.
  task automatic drive_packet(input logic [7:0] seed, input bit gappy, input int len);
    for (int i = 0; i < len; i++) begin
      DATA_IN    = pkt_byte(seed, i);
      P_SYNC_IN  = (i == 0);
      D_VALID_IN = 1'b1;
      tick();
      if (gappy) begin
        D_VALID_IN = 1'b0;
        P_SYNC_IN  = 1'b0;
        DATA_IN    = 8'h47;
        tick();
      end
    end
    D_VALID_IN = 1'b0;
    P_SYNC_IN  = 1'b0;
    DATA_IN    = 8'h00;
    if (len == LEN && model_cnt < SLOTS) begin
      push_packet(seed);
      model_cnt++;
    end
  endtask

  // Reads one packet; DATA_OUT byte n is expected after edge k+2+n.
  task automatic do_read(input bit do_accept, input int give_mid, input int rst_at, input string tag);
    int         bad;
    int         rd_bad;
    logic [7:0] exp;
    bad    = 0;
    rd_bad = 0;
    if (do_accept) begin
      GIVE_ME_ONE_PACKET = 1'b1;
      tick();
      GIVE_ME_ONE_PACKET = 1'b0;
      model_cnt--;
    end
    tick();
    for (int n = 0; n < LEN; n++) begin
      if (n == rst_at) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        check({tag, "_rst_data"}, DATA_OUT, 0);
        check({tag, "_rst_reading"}, READING, 0);
        check({tag, "_rst_count"}, PKT_COUNT, 0);
        check({tag, "_rst_full"}, GOT_FULL_PACKET, 0);
        check({tag, "_rst_drop"}, DROP_CNT, 0);
        check({tag, "_rst_err"}, SYNC_ERR_CNT, 0);
        return;
      end
      GIVE_ME_ONE_PACKET = (n == give_mid);
      tick();
      GIVE_ME_ONE_PACKET = 1'b0;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      if (DATA_OUT !== exp) begin
        if (bad == 0) $display("  %s first bad byte %0d: got %h expected %h", tag, n, DATA_OUT, exp);
        bad++;
      end
      if (READING !== 1'b1) rd_bad++;
    end
    check({tag, "_bad_bytes"}, bad, 0);
    check({tag, "_reading_gaps"}, rd_bad, 0);
    tick();
    check({tag, "_end_reading"}, READING, 0);
    check({tag, "_end_data"}, DATA_OUT, 0);
  endtask

  initial begin
    steps[0]  = '{OP_WRITE, 8'h00, 1'b0, 188, 1, 0, 0};
    steps[1]  = '{OP_READ,  8'h00, 1'b0,   0, 0, 0, 0};
    steps[2]  = '{OP_WRITE, 8'h00, 1'b1, 188, 1, 0, 0};
    steps[3]  = '{OP_READ,  8'h00, 1'b0,   0, 0, 0, 0};
    steps[4]  = '{OP_WRITE, 8'h01, 1'b0, 188, 1, 0, 0};
    steps[5]  = '{OP_WRITE, 8'h02, 1'b0, 188, 2, 0, 0};
    steps[6]  = '{OP_WRITE, 8'h03, 1'b0, 188, 3, 0, 0};
    steps[7]  = '{OP_WRITE, 8'h04, 1'b0, 188, 4, 0, 0};
    steps[8]  = '{OP_WRITE, 8'h05, 1'b0, 188, 4, 1, 0};
    steps[9]  = '{OP_READ,  8'h00, 1'b0,   0, 3, 1, 0};
    steps[10] = '{OP_READ,  8'h00, 1'b0,   0, 2, 1, 0};
    steps[11] = '{OP_READ,  8'h00, 1'b0,   0, 1, 1, 0};
    steps[12] = '{OP_READ,  8'h00, 1'b0,   0, 0, 1, 0};
    steps[13] = '{OP_WRITE, 8'h06, 1'b0, 100, 0, 1, 0};
    steps[14] = '{OP_WRITE, 8'h07, 1'b0, 188, 1, 1, 1};
    steps[15] = '{OP_READ,  8'h00, 1'b0,   0, 0, 1, 1};

    RST                = 1'b1;
    DATA_IN            = 8'h00;
    D_VALID_IN         = 1'b0;
    P_SYNC_IN          = 1'b0;
    GIVE_ME_ONE_PACKET = 1'b0;
    tick();
    tick();
    tick();
    RST = 1'b0;
    check("reset_data", DATA_OUT, 0);
    check("reset_reading", READING, 0);
    check("reset_count", PKT_COUNT, 0);
    check("reset_full", GOT_FULL_PACKET, 0);
    check("reset_drop", DROP_CNT, 0);
    check("reset_err", SYNC_ERR_CNT, 0);
    tick();

    for (int s = 0; s < 16; s++) begin
      if (steps[s].op == OP_WRITE)
        drive_packet(steps[s].seed, steps[s].gappy, steps[s].len);
      else
        do_read(1'b1, -1, -1, $sformatf("step%0d_read", s));
      check($sformatf("step%0d_count", s), PKT_COUNT, steps[s].exp_cnt);
      check($sformatf("step%0d_full", s), GOT_FULL_PACKET, (steps[s].exp_cnt != 0));
      check($sformatf("step%0d_drop", s), DROP_CNT, steps[s].exp_drop);
      check($sformatf("step%0d_err", s), SYNC_ERR_CNT, steps[s].exp_err);
      tick();
    end

    // Request with nothing stored is ignored.
    GIVE_ME_ONE_PACKET = 1'b1;
    tick();
    GIVE_ME_ONE_PACKET = 1'b0;
    check("empty_give_reading", READING, 0);
    check("empty_give_count", PKT_COUNT, 0);
    tick();
    tick();
    check("empty_give_data", DATA_OUT, 0);
    check("empty_give_reading_late", READING, 0);

    // Commit of packet 9 and accept of packet 8 on the same edge.
    drive_packet(8'h08, 1'b0, LEN);
    check("cc_pre_count", PKT_COUNT, 1);
    drive_packet(8'h09, 1'b0, LEN - 1);
    DATA_IN            = pkt_byte(8'h09, LEN - 1);
    D_VALID_IN         = 1'b1;
    P_SYNC_IN          = 1'b0;
    GIVE_ME_ONE_PACKET = 1'b1;
    tick();
    GIVE_ME_ONE_PACKET = 1'b0;
    D_VALID_IN         = 1'b0;
    DATA_IN            = 8'h00;
    push_packet(8'h09);
    check("cc_same_edge_count", PKT_COUNT, 1);
    check("cc_same_edge_full", GOT_FULL_PACKET, 1);
    do_read(1'b0, 20, -1, "cc_read8");
    check("cc_give_during_read_count", PKT_COUNT, 1);
    do_read(1'b1, -1, -1, "cc_read9");
    check("cc_final_count", PKT_COUNT, 0);
    tick();

    // Reset in the middle of a read burst, then a clean packet afterwards.
    drive_packet(8'h0A, 1'b0, LEN);
    do_read(1'b1, -1, 50, "rst_read");
    tick();
    drive_packet(8'h0B, 1'b0, LEN);
    check("post_rst_count", PKT_COUNT, 1);
    do_read(1'b1, -1, -1, "post_rst_read");
    check("post_rst_final_count", PKT_COUNT, 0);
    check("post_rst_drop", DROP_CNT, 0);
    check("post_rst_err", SYNC_ERR_CNT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
